// File: rtl/amba_pkg.sv
// Shared AMBA AHB-Lite / APB4 types and constants for the peripheral bus bridges.
package amba_pkg;

    typedef enum logic [1:0] {
        HTRANS_IDLE   = 2'd0,
        HTRANS_BUSY   = 2'd1,
        HTRANS_NONSEQ = 2'd2,
        HTRANS_SEQ    = 2'd3
    } htrans_t;

    localparam logic [2:0] HSIZE_BYTE = 3'd0;
    localparam logic [2:0] HSIZE_HALF = 3'd1;
    localparam logic [2:0] HSIZE_WORD = 3'd2;

    typedef enum logic [2:0] {
        BR_IDLE   = 3'd0,
        BR_LATCH  = 3'd1,
        BR_SETUP  = 3'd2,
        BR_ACCESS = 3'd3,
        BR_ERR1   = 3'd4,
        BR_ERR2   = 3'd5
    } br_state_t;

    localparam logic HRESP_OKAY  = 1'b0;
    localparam logic HRESP_ERROR = 1'b1;

    // AHB hprot[1:0] (privileged, data/opcode) to APB pprot {instr, nonsecure, privileged}
    function automatic logic [2:0] ahb_to_pprot(input logic [1:0] hprot_lo);
        return {~hprot_lo[0], 1'b0, hprot_lo[1]};
    endfunction

endpackage

// File: rtl/apb_strb_gen.sv
// Byte-strobe generator: AHB size and low address bits to APB pstrb (zero for reads).
module apb_strb_gen
    import amba_pkg::*;
#(
    parameter int unsigned STRBW = 4
) (
    input  logic [2:0]       hsize,
    input  logic [1:0]       addr_lo,
    input  logic             write,
    output logic [STRBW-1:0] strb_c
);

    // Sizes above word are handled as a full word
    always_comb begin
        strb_c = '0;
        if (write) begin
            case (hsize)
                HSIZE_BYTE: strb_c = STRBW'(1) << addr_lo;
                HSIZE_HALF: strb_c = STRBW'(3) << {addr_lo[1], 1'b0};
                default:    strb_c = '1;
            endcase
        end
    end

endmodule

// File: rtl/ahb2apb_bridge.sv
// AHB-Lite slave to APB4 master bridge: one transfer at a time, SETUP/ACCESS per transfer.
module ahb2apb_bridge
    import amba_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 16,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned NSLV       = 3
) (
    input  logic                       hclk,
    input  logic                       hresetn,
    input  logic                       hsel,
    input  logic [31:0]                haddr,
    input  logic [1:0]                 htrans,
    input  logic                       hwrite,
    input  logic [2:0]                 hsize,
    input  logic [3:0]                 hprot,
    input  logic [DATA_WIDTH-1:0]      hwdata,
    input  logic                       hready,
    output logic                       hreadyout,
    output logic                       hresp,
    output logic [DATA_WIDTH-1:0]      hrdata,
    output logic [ADDR_WIDTH-1:0]      paddr,
    output logic [NSLV-1:0]            psel,
    output logic                       penable,
    output logic                       pwrite,
    output logic [DATA_WIDTH-1:0]      pwdata,
    output logic [DATA_WIDTH/8-1:0]    pstrb,
    output logic [2:0]                 pprot,
    input  logic [NSLV*DATA_WIDTH-1:0] prdata,
    input  logic [NSLV-1:0]            pready,
    input  logic [NSLV-1:0]            pslverr
);

    localparam int unsigned IDXW  = (NSLV > 1) ? $clog2(NSLV) : 1;
    localparam int unsigned STRBW = DATA_WIDTH / 8;
    localparam logic [IDXW:0] NSLV_W = (IDXW + 1)'(NSLV);

    br_state_t             state_q;
    br_state_t             state_d;
    logic [IDXW-1:0]       idx_q;
    logic [IDXW-1:0]       idx_in;
    logic                  accept_c;
    logic                  unmapped_c;
    logic                  load_addr;
    logic                  load_wdata;
    logic                  psel_en;
    logic                  pready_sel;
    logic                  pslverr_sel;
    logic [DATA_WIDTH-1:0] prdata_sel;
    logic [STRBW-1:0]      strb_c;
    logic                  unused_bits;

    assign accept_c   = hsel && hready && htrans[1];
    assign idx_in     = haddr[ADDR_WIDTH +: IDXW];
    assign unmapped_c = ({1'b0, idx_in} >= NSLV_W);

    // Address bits above the slave index and the cacheable/bufferable hprot bits are don't-care
    assign unused_bits = ^{haddr[31:ADDR_WIDTH+IDXW], hprot[3:2], htrans[0]};

    apb_strb_gen #(
        .STRBW   (STRBW)
    ) u_strb (
        .hsize   (hsize),
        .addr_lo (haddr[1:0]),
        .write   (hwrite),
        .strb_c  (strb_c)
    );

    // Pick ready/error/read data of the currently addressed slave
    always_comb begin
        pready_sel  = 1'b0;
        pslverr_sel = 1'b0;
        prdata_sel  = '0;
        for (int i = 0; i < NSLV; i++) begin
            if (idx_q == IDXW'(i)) begin
                pready_sel  = pready[i];
                pslverr_sel = pslverr[i];
                prdata_sel  = prdata[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    // State register; async reset abandons any APB transfer in flight
    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            state_q <= BR_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and AHB/APB control outputs
    always_comb begin
        state_d    = state_q;
        hreadyout  = 1'b1;
        hresp      = HRESP_OKAY;
        hrdata     = '0;
        penable    = 1'b0;
        psel_en    = 1'b0;
        load_addr  = 1'b0;
        load_wdata = 1'b0;
        case (state_q)
            BR_IDLE: begin
                if (accept_c) begin
                    load_addr = 1'b1;
                    state_d   = unmapped_c ? BR_ERR1 : BR_LATCH;
                end
            end
            BR_LATCH: begin
                hreadyout  = 1'b0;
                load_wdata = 1'b1;
                state_d    = BR_SETUP;
            end
            BR_SETUP: begin
                hreadyout = 1'b0;
                psel_en   = 1'b1;
                state_d   = BR_ACCESS;
            end
            BR_ACCESS: begin
                hreadyout = 1'b0;
                psel_en   = 1'b1;
                penable   = 1'b1;
                if (pready_sel) begin
                    if (pslverr_sel) begin
                        state_d = BR_ERR1;
                    end else begin
                        hreadyout = 1'b1;
                        hrdata    = prdata_sel;
                        if (accept_c) begin
                            load_addr = 1'b1;
                            state_d   = unmapped_c ? BR_ERR1 : BR_LATCH;
                        end else begin
                            state_d = BR_IDLE;
                        end
                    end
                end
            end
            BR_ERR1: begin
                hresp     = HRESP_ERROR;
                hreadyout = 1'b0;
                state_d   = BR_ERR2;
            end
            BR_ERR2: begin
                hresp   = HRESP_ERROR;
                state_d = BR_IDLE;
            end
            default: begin
                state_d = BR_IDLE;
            end
        endcase
    end

    // One-hot select of the latched slave during SETUP and ACCESS only
    always_comb begin
        psel = '0;
        if (psel_en) begin
            for (int i = 0; i < NSLV; i++) begin
                psel[i] = (idx_q == IDXW'(i));
            end
        end
    end

    // Address-phase fields captured at accept, held through SETUP/ACCESS
    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            paddr  <= '0;
            idx_q  <= '0;
            pwrite <= 1'b0;
            pstrb  <= '0;
            pprot  <= '0;
        end else if (load_addr) begin
            paddr  <= haddr[ADDR_WIDTH-1:0];
            idx_q  <= idx_in;
            pwrite <= hwrite;
            pstrb  <= strb_c;
            pprot  <= ahb_to_pprot(hprot[1:0]);
        end
    end

    // Write data arrives in the AHB data phase, i.e. the LATCH cycle
    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            pwdata <= '0;
        end else if (load_wdata) begin
            pwdata <= hwdata;
        end
    end

endmodule

// File: tb/tb_ahb2apb_bridge.sv
// Scoreboard bench for ahb2apb_bridge: directed AHB transfers, AHB and APB monitors.
module tb_ahb2apb_bridge;
    import amba_pkg::*;

    logic        hclk;
    logic        hresetn;
    logic        hsel;
    logic [31:0] haddr;
    logic [1:0]  htrans;
    logic        hwrite;
    logic [2:0]  hsize;
    logic [3:0]  hprot;
    logic [31:0] hwdata;
    logic        hready;
    logic        hreadyout;
    logic        hresp;
    logic [31:0] hrdata;
    logic [15:0] paddr;
    logic [2:0]  psel;
    logic        penable;
    logic        pwrite;
    logic [31:0] pwdata;
    logic [3:0]  pstrb;
    logic [2:0]  pprot;
    logic [95:0] prdata;
    logic [2:0]  pready;
    logic [2:0]  pslverr;

    ahb2apb_bridge #(.ADDR_WIDTH(16), .DATA_WIDTH(32), .NSLV(3)) dut (
        .hclk(hclk), .hresetn(hresetn), .hsel(hsel), .haddr(haddr), .htrans(htrans),
        .hwrite(hwrite), .hsize(hsize), .hprot(hprot), .hwdata(hwdata), .hready(hready),
        .hreadyout(hreadyout), .hresp(hresp), .hrdata(hrdata), .paddr(paddr), .psel(psel),
        .penable(penable), .pwrite(pwrite), .pwdata(pwdata), .pstrb(pstrb), .pprot(pprot),
        .prdata(prdata), .pready(pready), .pslverr(pslverr)
    );

    typedef struct {
        logic        err;
        logic        rd;
        logic [31:0] rdata;
        int          acc;
        int          lat;
    } ahb_exp_t;

    typedef struct {
        logic [2:0]  sel;
        logic [15:0] addr;
        logic        wr;
        logic [31:0] wdata;
        logic [3:0]  strb;
        logic [2:0]  prot;
        int          setup;
    } apb_exp_t;

    ahb_exp_t ahb_q[$];
    apb_exp_t apb_q[$];
    int checks    = 0;
    int fails     = 0;
    int cyc       = 0;
    int wait_left = 0;

    initial begin
        hclk = 1'b0;
        forever #5 hclk = ~hclk;
    end

    always @(posedge hclk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: actual=0x%0h required=0x%0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge hclk);
        #1;
    endtask

    task automatic exp_ahb(input logic err, input logic rd, input logic [31:0] rdata, input int lat);
        ahb_exp_t e;
        e.err = err; e.rd = rd; e.rdata = rdata; e.acc = cyc; e.lat = lat;
        ahb_q.push_back(e);
    endtask

    task automatic exp_apb(input logic [2:0] sel, input logic [15:0] addr, input logic wr,
                           input logic [31:0] wd, input logic [3:0] st, input logic [2:0] pr);
        apb_exp_t a;
        a.sel = sel; a.addr = addr; a.wr = wr; a.wdata = wd; a.strb = st; a.prot = pr;
        a.setup = cyc + 2;
        apb_q.push_back(a);
    endtask

    // Address phase in the current cycle, data phase in the next
    task automatic issue(input logic [31:0] a, input logic wr, input logic [2:0] sz,
                         input logic [31:0] wd, input logic [3:0] pr, input int waits);
        hsel = 1'b1; haddr = a; htrans = 2'b10; hwrite = wr; hsize = sz; hprot = pr;
        wait_left = waits;
        step();
        hsel = 1'b0; htrans = 2'b00; haddr = '0; hwdata = wd;
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        while (n < 30) begin
            @(negedge hclk);
            if (hreadyout) break;
            n++;
        end
        if (n >= 30) begin
            checks++;
            fails++;
            $display("FAIL wait_done: hreadyout stayed low for 30 cycles");
        end
        step();
    endtask

    // Slave responder: hold pready low for wait_left ACCESS cycles
    initial begin
        forever begin
            @(posedge hclk);
            #1;
            if (psel != 3'b000 && penable) begin
                if (wait_left > 0) begin
                    pready = 3'b000;
                    wait_left--;
                end else begin
                    pready = 3'b111;
                end
            end else begin
                pready = 3'b111;
            end
        end
    end

    // AHB monitor: a transfer completes when hreadyout rises after wait states
    initial begin
        ahb_exp_t e;
        logic prev_rdy;
        prev_rdy = 1'b1;
        forever begin
            @(negedge hclk);
            if (!hresetn) begin
                prev_rdy = 1'b1;
            end else begin
                if (hreadyout && !prev_rdy) begin
                    if (ahb_q.size() == 0) begin
                        checks++;
                        fails++;
                        $display("FAIL ahb_unexpected: completion with hresp=%0d and no transfer pending", hresp);
                    end else begin
                        e = ahb_q.pop_front();
                        chk("hresp", 32'(hresp), 32'(e.err));
                        if (e.rd || e.err) chk("hrdata", hrdata, e.rdata);
                        chk("latency", 32'(cyc - e.acc), 32'(e.lat));
                    end
                end
                prev_rdy = hreadyout;
            end
        end
    end

    // APB monitor: check every SETUP cycle against the expected APB request
    initial begin
        apb_exp_t a;
        forever begin
            @(negedge hclk);
            if (hresetn && psel != 3'b000 && !penable) begin
                chk("psel_onehot", 32'($countones(psel)), 32'd1);
                if (apb_q.size() == 0) begin
                    checks++;
                    fails++;
                    $display("FAIL apb_unexpected: SETUP with psel=%b paddr=0x%0h", psel, paddr);
                end else begin
                    a = apb_q.pop_front();
                    chk("psel", 32'(psel), 32'(a.sel));
                    chk("paddr", 32'(paddr), 32'(a.addr));
                    chk("pwrite", 32'(pwrite), 32'(a.wr));
                    chk("pwdata", pwdata, a.wdata);
                    chk("pstrb", 32'(pstrb), 32'(a.strb));
                    chk("pprot", 32'(pprot), 32'(a.prot));
                    chk("setup_cycle", 32'(cyc), 32'(a.setup));
                end
            end
        end
    end

    initial begin
        #50000;
        $display("FAIL watchdog: simulation did not finish in time");
        fails++;
        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $fatal(1, "watchdog");
    end

    initial begin
        hresetn = 1'b0; hsel = 1'b0; haddr = '0; htrans = 2'b00; hwrite = 1'b0;
        hsize = 3'd0; hprot = 4'd0; hwdata = '0; hready = 1'b1;
        prdata = '0; pready = 3'b111; pslverr = 3'b000;

        #12;
        chk("rst_hreadyout", 32'(hreadyout), 32'd1);
        chk("rst_hresp", 32'(hresp), 32'd0);
        chk("rst_hrdata", hrdata, 32'd0);
        chk("rst_psel", 32'(psel), 32'd0);
        chk("rst_penable", 32'(penable), 32'd0);
        chk("rst_pwrite", 32'(pwrite), 32'd0);
        chk("rst_paddr", 32'(paddr), 32'd0);
        chk("rst_pwdata", pwdata, 32'd0);
        chk("rst_pstrb", 32'(pstrb), 32'd0);
        chk("rst_pprot", 32'(pprot), 32'd0);
        #10 hresetn = 1'b1;
        step();

        // IDLE and BUSY are zero-wait OKAY; NONSEQ with hready low is not accepted
        hsel = 1'b1; haddr = 32'h0001_0000; htrans = 2'b00;
        @(negedge hclk);
        chk("idle_hreadyout", 32'(hreadyout), 32'd1);
        chk("idle_hresp", 32'(hresp), 32'd0);
        step();
        htrans = 2'b01;
        @(negedge hclk);
        chk("busy_hreadyout", 32'(hreadyout), 32'd1);
        chk("busy_hresp", 32'(hresp), 32'd0);
        step();
        htrans = 2'b10; hready = 1'b0;
        step();
        hready = 1'b1; hsel = 1'b0; htrans = 2'b00;
        @(negedge hclk);
        chk("noaccept_hreadyout", 32'(hreadyout), 32'd1);
        step();

        // Word write to slave 1
        exp_apb(3'b010, 16'h0004, 1'b1, 32'hDEADBEEF, 4'hF, 3'b001);
        exp_ahb(1'b0, 1'b0, 32'h0, 3);
        issue(32'h0001_0004, 1'b1, HSIZE_WORD, 32'hDEADBEEF, 4'b0011, 0);
        wait_done();

        // Read slave 0 with five wait states
        prdata[31:0] = 32'h1234_5678;
        exp_apb(3'b001, 16'h0010, 1'b0, 32'h0, 4'h0, 3'b100);
        exp_ahb(1'b0, 1'b1, 32'h1234_5678, 8);
        issue(32'h0000_0010, 1'b0, HSIZE_WORD, 32'h0, 4'b0000, 5);
        wait_done();

        // Byte and half writes to slave 2
        exp_apb(3'b100, 16'h0003, 1'b1, 32'hAB00_0000, 4'b1000, 3'b000);
        exp_ahb(1'b0, 1'b0, 32'h0, 3);
        issue(32'h0002_0003, 1'b1, HSIZE_BYTE, 32'hAB00_0000, 4'b0001, 0);
        wait_done();
        exp_apb(3'b100, 16'h0002, 1'b1, 32'h5A5A_0000, 4'b1100, 3'b101);
        exp_ahb(1'b0, 1'b0, 32'h0, 3);
        issue(32'h0002_0002, 1'b1, HSIZE_HALF, 32'h5A5A_0000, 4'b0010, 0);
        wait_done();

        // Oversized hsize is a full word
        exp_apb(3'b001, 16'h0001, 1'b1, 32'h0102_0304, 4'hF, 3'b100);
        exp_ahb(1'b0, 1'b0, 32'h0, 3);
        issue(32'h0000_0001, 1'b1, 3'b011, 32'h0102_0304, 4'b0000, 0);
        wait_done();

        // Unmapped index 3: no APB cycle, two-cycle ERROR
        exp_ahb(1'b1, 1'b0, 32'h0, 2);
        issue(32'h0003_0000, 1'b1, HSIZE_WORD, 32'h1111_1111, 4'b0011, 0);
        @(negedge hclk);
        chk("err1_hreadyout", 32'(hreadyout), 32'd0);
        chk("err1_hresp", 32'(hresp), 32'd1);
        chk("err1_psel", 32'(psel), 32'd0);
        wait_done();

        // Slave 1 reports pslverr
        pslverr = 3'b010;
        prdata[63:32] = 32'h7777_7777;
        exp_apb(3'b010, 16'h0008, 1'b0, 32'h0, 4'h0, 3'b100);
        exp_ahb(1'b1, 1'b1, 32'h0, 5);
        issue(32'h0001_0008, 1'b0, HSIZE_WORD, 32'h0, 4'b0000, 0);
        wait_done();
        pslverr = 3'b000;

        // Back-to-back: read address phase on the write completion cycle
        prdata[95:64] = 32'hCAFE_F00D;
        exp_apb(3'b001, 16'h0020, 1'b1, 32'h0BAD_F00D, 4'hF, 3'b100);
        exp_ahb(1'b0, 1'b0, 32'h0, 3);
        issue(32'h0000_0020, 1'b1, HSIZE_WORD, 32'h0BAD_F00D, 4'b0000, 0);
        step();
        step();
        exp_apb(3'b100, 16'h0040, 1'b0, 32'h0, 4'h0, 3'b100);
        exp_ahb(1'b0, 1'b1, 32'hCAFE_F00D, 3);
        issue(32'h0002_0040, 1'b0, HSIZE_WORD, 32'h0, 4'b0000, 0);
        wait_done();

        // Asynchronous reset in the middle of a stalled ACCESS
        exp_apb(3'b001, 16'h0030, 1'b0, 32'h0, 4'h0, 3'b100);
        issue(32'h0000_0030, 1'b0, HSIZE_WORD, 32'h0, 4'b0000, 10);
        step();
        step();
        #2;
        chk("pre_rst_psel", 32'(psel), 32'b001);
        chk("pre_rst_penable", 32'(penable), 32'd1);
        hresetn = 1'b0;
        #1;
        chk("async_rst_psel", 32'(psel), 32'd0);
        chk("async_rst_penable", 32'(penable), 32'd0);
        chk("async_rst_hreadyout", 32'(hreadyout), 32'd1);
        chk("async_rst_hrdata", hrdata, 32'd0);
        wait_left = 0;
        pready = 3'b111;
        #10 hresetn = 1'b1;
        step();
        chk("post_rst_hreadyout", 32'(hreadyout), 32'd1);
        chk("post_rst_psel", 32'(psel), 32'd0);

        repeat (3) step();
        chk("ahb_q_drained", 32'(ahb_q.size()), 32'd0);
        chk("apb_q_drained", 32'(apb_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

endmodule
